dp_sram_bist: RTL

Parametrised built-in self-test controller for the dual-port SRAM macro, with port A write-only and port B read-only. It is the successor to the fixed 11-bit/32-bit incrementing-pattern bench stimulus. On `start` it writes a selectable data pattern to every address through port A, then reads every address back through port B with configurable read latency. It compares each word against the expected value, counts mismatches and reports pass/fail. It sits between the chip test controller and the SRAM macro pins.

---
 rtl/dp_sram_bist.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/dp_sram_bist.sv
// dp_sram_bist: self-test controller for a dual-port SRAM macro (port A
// write-only, port B read-only). On start it writes a pattern to every
// address, reads each address back, compares the data, counts mismatches
// and reports pass/fail.
// Optional first-error capture ports: define DP_SRAM_BIST_ERRLOG_EN.
module dp_sram_bist #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 2048,
  parameter int unsigned RD_LAT = 1,
  parameter logic [31:0] SIG    = 32'hECEB0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_cnt,
  output logic              sram_cena,
  output logic              sram_wena,
  output logic [ADDR_W-1:0] sram_aa,
  output logic [DATA_W-1:0] sram_da,
  output logic              sram_cenb,
  output logic              sram_wenb,
  output logic [ADDR_W-1:0] sram_ab,
  input  logic [DATA_W-1:0] sram_qb,
  output logic              sram_retn
`ifdef DP_SRAM_BIST_ERRLOG_EN
  ,
  output logic              first_err_vld,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_data
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
  localparam logic [DATA_W-1:0] BASE       = DATA_W'(SIG);
  localparam logic [1:0]        DRAIN_LAST = 2'(RD_LAT - 1);

  state_t            state, state_n;
  logic [1:0]        mode_r, mode_n;
  logic [1:0]        drain_cnt, drain_cnt_n;
  logic              busy_n, done_n, pass_n;
  logic              cena_n, cenb_n;
  logic [ADDR_W-1:0] aa_n, ab_n;
  logic [DATA_W-1:0] da_n;
  logic              clr;

  // Read-compare pipeline: expected word travels alongside the SRAM read.
  logic              pipe_vld [RD_LAT];
  logic [DATA_W-1:0] pipe_exp [RD_LAT];
  logic              mismatch;

  // Expected word for a given mode and address (mode 3 behaves as mode 0).
  function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m,
                                                input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] w;
    w = BASE + DATA_W'(a);
    case (m)
      2'd1: w = ~(BASE + DATA_W'(a));
      2'd2: begin
        for (int unsigned i = 0; i < DATA_W; i++) begin
          w[i] = (i[0] == a[0]);
        end
      end
      default: w = BASE + DATA_W'(a);
    endcase
    return w;
  endfunction

  assign sram_wena = 1'b0;
  assign sram_wenb = 1'b1;

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_n     = state;
    mode_n      = mode_r;
    drain_cnt_n = drain_cnt;
    cena_n      = 1'b1;
    cenb_n      = 1'b1;
    aa_n        = sram_aa;
    ab_n        = sram_ab;
    da_n        = sram_da;
    done_n      = done;
    pass_n      = pass;
    clr         = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          clr     = 1'b1;
          mode_n  = mode;
          done_n  = 1'b0;
          pass_n  = 1'b0;
          state_n = S_WRITE;
          cena_n  = 1'b0;
          aa_n    = '0;
          da_n    = pattern(mode, '0);
        end
      end
      S_WRITE: begin
        if (sram_aa == LAST_ADDR) begin
          state_n = S_READ;
          cenb_n  = 1'b0;
          ab_n    = '0;
        end else begin
          cena_n = 1'b0;
          aa_n   = sram_aa + 1'b1;
          da_n   = pattern(mode_r, sram_aa + 1'b1);
        end
      end
      S_READ: begin
        if (sram_ab == LAST_ADDR) begin
          state_n     = S_DRAIN;
          drain_cnt_n = '0;
        end else begin
          cenb_n = 1'b0;
          ab_n   = sram_ab + 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_cnt == DRAIN_LAST) begin
          state_n = S_DONE;
        end else begin
          drain_cnt_n = drain_cnt + 2'd1;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
        done_n  = 1'b1;
        pass_n  = (err_cnt == 16'd0);
      end
      default: state_n = S_IDLE;
    endcase
    // busy stays high through the edge that raises done, dropping one edge later
    busy_n = (state_n != S_IDLE) || (state == S_DONE);
  end

  // State and registered control/SRAM outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      mode_r    <= 2'd0;
      drain_cnt <= 2'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      sram_cena <= 1'b1;
      sram_cenb <= 1'b1;
      sram_aa   <= '0;
      sram_ab   <= '0;
      sram_da   <= '0;
    end else begin
      state     <= state_n;
      mode_r    <= mode_n;
      drain_cnt <= drain_cnt_n;
      busy      <= busy_n;
      done      <= done_n;
      pass      <= pass_n;
      sram_cena <= cena_n;
      sram_cenb <= cenb_n;
      sram_aa   <= aa_n;
      sram_ab   <= ab_n;
      sram_da   <= da_n;
    end
  end

  // Retention follows reset, one edge late.
  always_ff @(posedge clk) begin
    sram_retn <= ~rst;
  end

  // Valid bits of the compare pipeline, entered with each issued read.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        pipe_vld[i] <= 1'b0;
      end
    end else begin
      pipe_vld[0] <= ~cenb_n;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
      end
    end
  end

  // Expected words of the compare pipeline; qualified by the valid bits.
  always_ff @(posedge clk) begin
    pipe_exp[0] <= pattern(mode_r, ab_n);
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      pipe_exp[i] <= pipe_exp[i-1];
    end
  end

  assign mismatch = pipe_vld[RD_LAT-1] && (sram_qb != pipe_exp[RD_LAT-1]);

  // Saturating mismatch counter, cleared by an accepted start.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      err_cnt <= 16'd0;
    end else if (mismatch && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end

`ifdef DP_SRAM_BIST_ERRLOG_EN
  logic [ADDR_W-1:0] pipe_addr [RD_LAT];

  // Address of each read travels with its expected word for the error log.
  always_ff @(posedge clk) begin
    pipe_addr[0] <= ab_n;
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      pipe_addr[i] <= pipe_addr[i-1];
    end
  end

  // Capture address and data of the first mismatch of a run only.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      first_err_vld  <= 1'b0;
      first_err_addr <= '0;
      first_err_data <= '0;
    end else if (mismatch && !first_err_vld) begin
      first_err_vld  <= 1'b1;
      first_err_addr <= pipe_addr[RD_LAT-1];
      first_err_data <= sram_qb;
    end
  end
`endif

endmodule
